// File: rtl/iir_biquad_seq.sv
// iir_biquad_seq
// Direct-form-I biquad: y[n] = sat(round((b0*x + b1*x1 + b2*x2 - a1*y1 - a2*y2) / 2^FRAC))
// Five coefficient products per sample share one multiplier over five MAC cycles.
//
// Ports
//   clk         rising-edge clock
//   rst_n       asynchronous reset, active HIGH despite the name
//   clr         synchronous clear of history and in-flight work
//   in_valid    input sample valid
//   in_data     signed input sample x[n]
//   in_ready    block accepts a sample this cycle
//   coef_we     shadow-bank coefficient write strobe
//   coef_addr   0=b0 1=b1 2=b2 3=a1 4=a2, 5..7 ignored
//   coef_wdata  signed coefficient value
//   out_valid   one-cycle pulse, out_data/out_sat valid
//   out_data    signed output sample y[n]
//   out_sat     y[n] was clamped
module iir_biquad_seq #(
  parameter int DW   = 12,
  parameter int CW   = 12,
  parameter int FRAC = 10
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 clr,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_data,
  output logic                 in_ready,
  input  logic                 coef_we,
  input  logic [2:0]           coef_addr,
  input  logic signed [CW-1:0] coef_wdata,
  output logic                 out_valid,
  output logic signed [DW-1:0] out_data,
  output logic                 out_sat
);

  localparam int PW = DW + CW;
  localparam int AW = DW + CW + 3;

  localparam logic signed [AW-1:0] HALF = AW'(1) << (FRAC - 1);
  localparam logic signed [AW-1:0] YMAX = (AW'(1) << (DW - 1)) - AW'(1);
  localparam logic signed [AW-1:0] YMIN = ~YMAX;

  typedef enum logic [1:0] {IDLE, MAC, DONE} state_t;

  state_t                state;
  logic [2:0]            k;
  logic signed [AW-1:0]  acc;
  logic signed [DW-1:0]  x_cur;
  logic signed [DW-1:0]  x1;
  logic signed [DW-1:0]  x2;
  logic signed [DW-1:0]  y1;
  logic signed [DW-1:0]  y2;

  logic signed [CW-1:0]  shadow [5];
  logic signed [CW-1:0]  active [5];

  logic                  accept;
  logic signed [PW-1:0]  mul_coef;
  logic signed [PW-1:0]  mul_data;
  logic signed [PW-1:0]  prod;
  logic signed [AW-1:0]  prod_ext;
  logic signed [AW-1:0]  acc_next;
  logic signed [AW-1:0]  y_round;
  logic [DW:0]           sat_res;
  logic signed [DW-1:0]  y_sat;
  logic                  y_sat_flag;

  function automatic logic signed [CW-1:0] coef_default(input int idx);
    case (idx)
      0:       coef_default = CW'(1006);
      1:       coef_default = CW'(-1911);
      2:       coef_default = CW'(1006);
      default: coef_default = '0;
    endcase
  endfunction

  // Round half up: add half an LSB of the output scale, then arithmetic shift.
  function automatic logic signed [AW-1:0] round_acc(input logic signed [AW-1:0] a);
    logic signed [AW-1:0] r;
    r = (a + HALF) >>> FRAC;
    return r;
  endfunction

  // Returns {clamped_flag, clamped_value}.
  function automatic logic [DW:0] sat_acc(input logic signed [AW-1:0] v);
    logic [DW:0] r;
    if (v > YMAX)      r = {1'b1, YMAX[DW-1:0]};
    else if (v < YMIN) r = {1'b1, YMIN[DW-1:0]};
    else               r = {1'b0, v[DW-1:0]};
    return r;
  endfunction

  assign in_ready = (state == IDLE) && !clr;
  assign accept   = in_valid && in_ready;

  // Shared multiplier operand select; operands sign-extended to the product width.
  always_comb begin
    mul_coef = '0;
    mul_data = '0;
    case (k)
      3'd0: begin
        mul_coef = {{DW{active[0][CW-1]}}, active[0]};
        mul_data = {{CW{x_cur[DW-1]}}, x_cur};
      end
      3'd1: begin
        mul_coef = {{DW{active[1][CW-1]}}, active[1]};
        mul_data = {{CW{x1[DW-1]}}, x1};
      end
      3'd2: begin
        mul_coef = {{DW{active[2][CW-1]}}, active[2]};
        mul_data = {{CW{x2[DW-1]}}, x2};
      end
      3'd3: begin
        mul_coef = {{DW{active[3][CW-1]}}, active[3]};
        mul_data = {{CW{y1[DW-1]}}, y1};
      end
      3'd4: begin
        mul_coef = {{DW{active[4][CW-1]}}, active[4]};
        mul_data = {{CW{y2[DW-1]}}, y2};
      end
      default: begin
        mul_coef = '0;
        mul_data = '0;
      end
    endcase
  end

  // Feedback terms (k=3,4) are subtracted.
  always_comb begin
    prod     = mul_coef * mul_data;
    prod_ext = {{(AW-PW){prod[PW-1]}}, prod};
    acc_next = (k >= 3'd3) ? (acc - prod_ext) : (acc + prod_ext);
  end

  always_comb begin
    y_round    = round_acc(acc);
    sat_res    = sat_acc(y_round);
    y_sat      = sat_res[DW-1:0];
    y_sat_flag = sat_res[DW];
  end

  // Coefficient banks: the active bank only changes on an accepted sample, so a
  // write landing in the acceptance cycle goes to the shadow bank and reaches the
  // following sample.
  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      for (int i = 0; i < 5; i++) begin
        shadow[i] <= coef_default(i);
        active[i] <= coef_default(i);
      end
    end else begin
      if (accept) begin
        for (int i = 0; i < 5; i++) active[i] <= shadow[i];
      end
      if (coef_we) begin
        case (coef_addr)
          3'd0:    shadow[0] <= coef_wdata;
          3'd1:    shadow[1] <= coef_wdata;
          3'd2:    shadow[2] <= coef_wdata;
          3'd3:    shadow[3] <= coef_wdata;
          3'd4:    shadow[4] <= coef_wdata;
          default: ;
        endcase
      end
    end
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      x_cur     <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      out_sat   <= 1'b0;
    end else if (clr) begin
      state     <= IDLE;
      k         <= '0;
      acc       <= '0;
      x1        <= '0;
      x2        <= '0;
      y1        <= '0;
      y2        <= '0;
      out_valid <= 1'b0;
    end else begin
      out_valid <= 1'b0;
      case (state)
        // Capture stage: latch x[n] and start a fresh accumulation.
        IDLE: begin
          if (accept) begin
            x_cur <= in_data;
            acc   <= '0;
            k     <= '0;
            state <= MAC;
          end
        end
        // MAC stage: one product per cycle, k = 0..4.
        MAC: begin
          acc <= acc_next;
          k   <= k + 3'd1;
          if (k == 3'd4) state <= DONE;
        end
        // Output stage: round, clamp, publish and advance the history.
        DONE: begin
          out_data  <= y_sat;
          out_sat   <= y_sat_flag;
          out_valid <= 1'b1;
          x2        <= x1;
          x1        <= x_cur;
          y2        <= y1;
          y1        <= y_sat;
          state     <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_iir_biquad_seq.sv
module tb_iir_biquad_seq;
  localparam int DW   = 12;
  localparam int CW   = 12;
  localparam int FRAC = 10;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 clr;
  logic                 in_valid;
  logic signed [DW-1:0] in_data;
  logic                 in_ready;
  logic                 coef_we;
  logic [2:0]           coef_addr;
  logic signed [CW-1:0] coef_wdata;
  logic                 out_valid;
  logic signed [DW-1:0] out_data;
  logic                 out_sat;

  iir_biquad_seq #(.DW(DW), .CW(CW), .FRAC(FRAC)) dut (
    .clk(clk), .rst_n(rst_n), .clr(clr),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .coef_we(coef_we), .coef_addr(coef_addr), .coef_wdata(coef_wdata),
    .out_valid(out_valid), .out_data(out_data), .out_sat(out_sat)
  );

  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  task automatic chk(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------- behavioural model ----------------
  int  m_sh [5];
  int  m_act [5];
  int  mx1, mx2, my1, my2;
  int  m_cnt;            // clocks until the pending result appears; 0 = idle
  int  pend_x, pend_y;
  bit  pend_s;
  bit  e_valid;
  int  e_data;
  bit  e_sat;
  bit  acc_evt;
  int  cyc = 0;
  int  acc_cyc_q [$];
  int  vcyc_q [$];
  int  got_q [$];
  int  sat_q [$];

  function automatic void model_y(input int x, output int y, output bit s);
    longint sum, t, q;
    sum = longint'(m_act[0]) * x + longint'(m_act[1]) * mx1 + longint'(m_act[2]) * mx2
        - longint'(m_act[3]) * my1 - longint'(m_act[4]) * my2;
    t = sum + (longint'(1) << (FRAC - 1));
    q = (t >= 0) ? t / (longint'(1) << FRAC)
                 : -((-t + (longint'(1) << FRAC) - 1) / (longint'(1) << FRAC));
    s = 1'b0;
    if (q > 2047)       begin q = 2047;  s = 1'b1; end
    else if (q < -2048) begin q = -2048; s = 1'b1; end
    y = int'(q);
  endfunction

  always @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      m_sh  = '{1006, -1911, 1006, 0, 0};
      m_act = '{1006, -1911, 1006, 0, 0};
      mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      m_cnt = 0; e_valid = 1'b0; e_data = 0; e_sat = 1'b0; acc_evt = 1'b0;
    end else begin
      acc_evt = 1'b0;
      e_valid = 1'b0;
      if (clr) begin
        m_cnt = 0; mx1 = 0; mx2 = 0; my1 = 0; my2 = 0;
      end else if (m_cnt > 0) begin
        m_cnt--;
        if (m_cnt == 0) begin
          e_valid = 1'b1; e_data = pend_y; e_sat = pend_s;
          mx2 = mx1; mx1 = pend_x; my2 = my1; my1 = pend_y;
        end
      end else if (in_valid) begin
        m_act = m_sh;
        pend_x = in_data;
        model_y(pend_x, pend_y, pend_s);
        m_cnt = 6;
        acc_evt = 1'b1;
        acc_cyc_q.push_back(cyc);
      end
      if (coef_we && coef_addr < 3'd5) m_sh[coef_addr] = coef_wdata;
    end
  end

  // ---------------- per-cycle compare ----------------
  always @(negedge clk) begin
    chk("in_ready", in_ready, (m_cnt == 0) && !clr);
    chk("out_valid", out_valid, e_valid);
    if (e_valid) begin
      chk("out_data", out_data, e_data);
      chk("out_sat", out_sat, e_sat);
    end
    if (out_valid) begin
      got_q.push_back(out_data);
      sat_q.push_back(out_sat);
      vcyc_q.push_back(cyc);
    end
    cyc++;
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge clk);
    #1;
  endtask

  task automatic wcoef(input int addr, input int val);
    coef_we = 1'b1; coef_addr = 3'(addr); coef_wdata = CW'(val);
    tick(1);
    coef_we = 1'b0;
  endtask

  task automatic pulse_clr();
    clr = 1'b1; tick(1); clr = 1'b0;
  endtask

  task automatic start(input int x);
    bit ok;
    ok = 1'b0;
    in_valid = 1'b1; in_data = DW'(x);
    for (int t = 0; t < 30; t++) begin
      tick(1);
      if (acc_evt) begin ok = 1'b1; break; end
    end
    if (!ok) chk("accept_timeout", 0, 1);
    in_valid = 1'b0;
  endtask

  task automatic send(input int x);
    start(x);
    tick(6);
  endtask

  function automatic int got_at(input int i);
    return (i < got_q.size()) ? got_q[i] : 99999;
  endfunction

  function automatic int sat_at(input int i);
    return (i < sat_q.size()) ? sat_q[i] : 9;
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int exp_def [5];
    int exp_pole [6];
    logic [31:0] r;
    exp_def  = '{982, -1866, 982, 0, 0};
    exp_pole = '{1000, 500, 250, 125, 63, 32};

    rst_n = 1'b1; clr = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;
    tick(3);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_out_sat", out_sat, 0);
    chk("rst_in_ready", in_ready, 1);
    rst_n = 1'b0;
    tick(2);

    // Default coefficients, impulse response.
    got_q.delete(); sat_q.delete();
    send(1000);
    repeat (4) send(0);
    chk("def_count", got_q.size(), 5);
    for (int i = 0; i < 5; i++) begin
      chk("def_y", got_at(i), exp_def[i]);
      chk("def_sat", sat_at(i), 0);
    end

    // Single pole at 0.5: decays to the rounding limit cycle of 1.
    wcoef(0, 1024); wcoef(1, 0); wcoef(2, 0); wcoef(3, -512); wcoef(4, 0);
    pulse_clr();
    got_q.delete(); sat_q.delete();
    send(1000);
    repeat (11) send(0);
    for (int i = 0; i < 6; i++) chk("pole_y", got_at(i), exp_pole[i]);
    chk("pole_settle", got_at(11), 1);

    // Saturation boundaries.
    wcoef(0, 2047); wcoef(3, 0);
    pulse_clr();
    got_q.delete(); sat_q.delete();
    send(2047); send(-2048); send(100);
    chk("sat_hi_y", got_at(0), 2047);   chk("sat_hi_f", sat_at(0), 1);
    chk("sat_lo_y", got_at(1), -2048);  chk("sat_lo_f", sat_at(1), 1);
    chk("sat_mid_y", got_at(2), 200);   chk("sat_mid_f", sat_at(2), 0);

    // Back-to-back acceptance with in_valid held high.
    acc_cyc_q.delete(); vcyc_q.delete();
    begin
      int n;
      n = 0;
      in_valid = 1'b1; r = $urandom; in_data = r[DW-1:0];
      for (int t = 0; t < 60 && n < 4; t++) begin
        tick(1);
        if (acc_evt) begin n++; r = $urandom; in_data = r[DW-1:0]; end
      end
      in_valid = 1'b0;
      tick(8);
    end
    chk("b2b_accepts", acc_cyc_q.size(), 4);
    chk("b2b_outputs", vcyc_q.size(), 4);
    if (acc_cyc_q.size() == 4 && vcyc_q.size() == 4) begin
      for (int i = 0; i < 4; i++) chk("b2b_latency", vcyc_q[i] - acc_cyc_q[i], 6);
      for (int i = 1; i < 4; i++) chk("b2b_spacing", acc_cyc_q[i] - acc_cyc_q[i-1], 7);
    end

    // Coefficient write during MAC only reaches the next sample.
    wcoef(0, 1024);
    pulse_clr();
    got_q.delete();
    start(500);
    wcoef(0, 0);
    tick(5);
    send(500);
    chk("cw_old", got_at(0), 500);
    chk("cw_new", got_at(1), 0);

    // clr during MAC drops the sample; history restarts from zero.
    wcoef(0, 1006); wcoef(1, -1911); wcoef(2, 1006); wcoef(3, 0); wcoef(4, 0);
    pulse_clr();
    got_q.delete();
    start(1000);
    tick(2);
    clr = 1'b1; tick(1); clr = 1'b0;
    tick(6);
    chk("clr_no_out", got_q.size(), 0);
    send(1000); send(0); send(0);
    for (int i = 0; i < 3; i++) chk("clr_y", got_at(i), exp_def[i]);

    // Asynchronous reset mid-MAC.
    got_q.delete();
    start(1000);
    tick(2);
    rst_n = 1'b1;
    #2;
    chk("arst_out_valid", out_valid, 0);
    chk("arst_out_data", out_data, 0);
    chk("arst_out_sat", out_sat, 0);
    chk("arst_in_ready", in_ready, 1);
    #1;
    rst_n = 1'b0;
    tick(1);
    tick(6);
    chk("arst_no_out", got_q.size(), 0);
    send(1000); send(0); send(0);
    for (int i = 0; i < 3; i++) chk("arst_y", got_at(i), exp_def[i]);

    // Randomized traffic: coefficients, handshakes, writes and clears.
    for (int a = 0; a < 5; a++) begin
      r = $urandom; wcoef(a, int'($signed(r[CW-1:0])));
    end
    for (int c = 0; c < 2000; c++) begin
      r = $urandom;
      in_valid   = r[0] | r[1];
      clr        = (r[7:2] == 6'd0);
      coef_we    = (r[11:8] == 4'd0);
      coef_addr  = r[14:12];
      r = $urandom;
      in_data    = r[DW-1:0];
      coef_wdata = r[DW+CW-1:DW];
      tick(1);
    end
    in_valid = 1'b0; clr = 1'b0; coef_we = 1'b0;
    tick(10);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/iir_biquad_seq.md
# iir_biquad_seq

Parametrised second-order IIR section (direct form I) that computes the full biquad, numerator zeros plus denominator poles, with one shared multiplier stepped over five coefficient products per sample. It follows the fixed three-tap zero stage in the IIR datapath. It adds runtime-loadable coefficients, a valid/ready sample handshake, rounding, output saturation and a synchronous history clear.

## Interface
- DW, 12: input/output sample width, signed.
- CW, 12: coefficient width, signed.
- FRAC, 10: coefficient fraction bits; product sum is scaled by 2^-FRAC.
- clk  in  1  clock; all state changes on the rising edge.
- rst_n  in  1  asynchronous, active-high reset. The name is historical; a 1 resets.
- clr  in  1  synchronous clear of history and in-flight computation.
- in_valid  in  1  input sample valid.
- in_data  in  DW  signed input sample x[n].
- in_ready  out  1  block can accept a sample this cycle.
- coef_we  in  1  coefficient write strobe.
- coef_addr  in  3  0=b0, 1=b1, 2=b2, 3=a1, 4=a2; 5..7 ignored.
- coef_wdata  in  CW  signed coefficient value.
- out_valid  out  1  one-cycle pulse, out_data valid.
- out_data  out  DW  signed output sample y[n].
- out_sat  out  1  y[n] was saturated; valid with out_valid.

## Operation
- Transfer function: y[n] = sat(round((b0·x[n] + b1·x[n-1] + b2·x[n-2] − a1·y[n-1] − a2·y[n-2]) / 2^FRAC)).
- Accumulator width is DW+CW+3, so no internal overflow is possible.
- Rounding: add 2^(FRAC-1), then arithmetic shift right by FRAC (round half up).
- Saturation: clamp to [−2^(DW-1), 2^(DW-1)−1]. out_sat=1 when clamped.
- Feedback history y[n-1] and y[n-2] stores the saturated value.
- Coefficients use two banks:
  - coef_we writes the shadow bank at any time.
  - The active bank is copied from the shadow bank on each accepted sample, so a computation never sees a mixed set.
- Reset coefficients (both banks): b0=1006, b1=−1911, b2=1006, a1=0, a2=0.
- FSM states:
  - IDLE: in_ready=1. Handshake in_valid&&in_ready captures x, loads the active bank, clears the accumulator, sets k=0, goes to MAC.
  - MAC: each cycle accumulates product k (order b0·x, b1·x1, b2·x2, −a1·y1, −a2·y2), then increments k. After k=4 goes to DONE.
  - DONE: registers the rounded and saturated out_data and out_sat, pulses out_valid, shifts history (x2←x1, x1←x, y2←y1, y1←y), goes to IDLE.
- clr (synchronous, highest priority after reset):
  - zeroes x1, x2, y1, y2 and the accumulator;
  - forces IDLE; out_valid=0 that cycle; a sample in MAC or DONE is dropped;
  - coefficients are unaffected.
- in_ready = (state==IDLE) && !clr. A sample presented with clr high is not accepted.
- coef_we with coef_addr 5..7 has no effect.

## Timing
- Reset values:
  - outputs: out_valid=0, out_sat=0, out_data=0, in_ready=1;
  - state: history 0, state IDLE, coefficients at their defaults.
- Acceptance at edge E0. Accumulation at edges E1..E5. out_valid high in the cycle following E6.
- Latency is 6 clocks from acceptance to out_valid.
- Throughput is one sample per 7 clocks. in_ready is high in the same cycle as out_valid, so back-to-back acceptance occurs at E7, E14, …
- in_ready is low during MAC and DONE. in_valid during those states is ignored and not queued.
- A coef_we in the same cycle as sample acceptance is not applied to that sample; it is applied to the next one.
- Asynchronous reset mid-computation discards everything, with no output pulse.

## Test plan
- Default coefficients, impulse x=1000 then zeros → y = 982, −1866, 982, 0, 0; out_sat=0.
- Load b0=1024, b1=b2=0, a1=−512, a2=0; impulse 1000 → y = 1000, 500, 250, 125, 63, 32, then settles at 1 (rounding limit cycle).
- b0=2047, others 0:
  - x=2047 → y=2047, out_sat=1;
  - x=−2048 → y=−2048, out_sat=1;
  - x=100 → y=200, out_sat=0.
- in_valid held high for 4 samples → out_valid pulses exactly 6 clocks after each acceptance, acceptances 7 clocks apart, in_ready low for 6 clocks after each.
- Write b0=0 while in MAC → current y uses the old b0; the next sample's y uses 0.
- Run a default-coefficient impulse, assert clr during MAC k=2 → no out_valid. A new impulse 1000 then reproduces 982, −1866, 982. Repeat with rst_n pulsed mid-MAC → same result, outputs at reset values.
